// File: rtl/cordic_pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// cordic_pipe_stage_bank
//
// Elastic register bank that carries CHANNELS lock-stepped words of WIDTH bits
// through DEPTH stages. It sits between CORDIC iteration stages. A valid/ready
// handshake moves the words. Empty stages always accept, so bubbles close up
// while downstream is stalled. A synchronous clear drops every beat in the
// bank.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low; empties the bank and zeroes the data
//   clear      synchronous flush, active-high; overrides all other inputs
//   in_valid   an input beat is present
//   in_ready   the bank takes the input beat this cycle
//   in_data    CHANNELS*WIDTH bits; channel c is in_data[c*WIDTH +: WIDTH]
//   out_valid  an output beat is present (last stage holds a beat)
//   out_ready  downstream takes the output beat
//   out_data   last-stage data, packed the same way as in_data
//   occupancy  number of stages that currently hold a beat, 0..DEPTH
// -----------------------------------------------------------------------------
module cordic_pipe_stage_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;           // stage holds a beat
  logic [DW-1:0]    d [DEPTH];   // stage data, all channels together
  logic [DEPTH-1:0] rdy;         // stage can take a beat on the next edge
  logic [DEPTH-1:0] src_v;       // valid arriving at each stage
  logic [DW-1:0]    src_d [DEPTH];
  logic             in_fire;

  // A stage is ready when it is empty or the stage after it is ready. The
  // last stage is ready when it is empty or downstream is ready. This folds
  // to: stage i is ready if out_ready is high or any stage i..DEPTH-1 is
  // empty. The loop runs from the output end and keeps a running OR, so
  // rdy never feeds back into itself.
  always_comb begin
    logic acc;
    // NOTE: in always_comb every target gets a value on every path, and
    // temporaries use blocking '='. Otherwise a latch is inferred or the
    // value from the previous iteration leaks through.
    rdy = '0;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~clear;
  assign out_valid = v[DEPTH-1] & ~clear;
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;

  // Source of each stage: the input port for stage 0, the previous stage
  // for every other stage.
  always_comb begin
    src_v[0] = in_fire;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Valid chain. clear empties the bank in one edge. A ready stage takes the
  // valid bit from upstream. A stalled stage keeps its own valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
    end else if (clear) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) v[i] <= src_v[i];
      end
    end
  end

  // Data chain. A stage loads only when it is ready and a real beat arrives.
  // Empty stages, stalled stages and flushed stages keep their old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data array is reset on purpose, even though that costs a
      // reset net on every data flop. out_data must read zero during reset.
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end

  // Occupancy is the number of valid stages right now. It does not look
  // ahead to the next edge.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_cordic_pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// tb_cordic_pipe_stage_bank
//
// Scoreboard bench for cordic_pipe_stage_bank. It builds three instances:
// the default 16x2x4 bank, a 1x1x1 bank and a 24x4x8 bank. The stimulus
// pushes each accepted beat into a per-instance queue. A monitor per
// instance pops the queue and compares whenever an output transfer is
// presented.
// -----------------------------------------------------------------------------
module tb_cordic_pipe_stage_bank;

  logic clk;
  logic reset;

  // Instance 0: WIDTH 16, CHANNELS 2, DEPTH 4
  logic        clear0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [2:0]  occ0;
  // Instance 1: WIDTH 1, CHANNELS 1, DEPTH 1
  logic        clear1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0]  in_data1, out_data1;
  logic [0:0]  occ1;
  // Instance 2: WIDTH 24, CHANNELS 4, DEPTH 8
  logic        clear2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [95:0] in_data2, out_data2;
  logic [3:0]  occ2;

  logic [31:0] q0[$];
  logic [0:0]  q1[$];
  logic [95:0] q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  cordic_pipe_stage_bank #(.WIDTH(16), .CHANNELS(2), .DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .clear(clear0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occ0)
  );

  cordic_pipe_stage_bank #(.WIDTH(1), .CHANNELS(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  cordic_pipe_stage_bank #(.WIDTH(24), .CHANNELS(4), .DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .occupancy(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: an output transfer is out_valid & out_ready sampled on the
  // falling edge. Inputs change only just after the rising edge.
  always @(negedge clk) begin
    if (reset && out_valid0 && out_ready0) begin
      check("out0_expected", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) check("out0_data", 128'(out_data0), 128'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid1 && out_ready1) begin
      check("out1_expected", 128'(q1.size() != 0), 128'(1));
      if (q1.size() != 0) check("out1_data", 128'(out_data1), 128'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid2 && out_ready2) begin
      check("out2_expected", 128'(q2.size() != 0), 128'(1));
      if (q2.size() != 0) check("out2_data", 128'(out_data2), 128'(q2.pop_front()));
    end
  end

  // Watchdog: stop the run if something hangs.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Call this just after a rising edge. It returns just after the edge that
  // accepted the beat. When keep is set, the beat is pushed to the scoreboard.
  task automatic send0(input logic [31:0] x, input bit keep);
    int w;
    w = 0;
    in_valid0 = 1'b1;
    in_data0  = x;
    @(negedge clk);
    while (!in_ready0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("send0_accept", 128'(in_ready0), 128'(1));
    if (in_ready0 && keep) q0.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Wait, with a bound, until a scoreboard queue drains.
  task automatic drain(input int which);
    int w;
    w = 0;
    while (qsize(which) != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    check("drain_queue_empty", 128'(qsize(which)), 128'(0));
  endtask

  initial begin
    int  lat, c, n_acc, max_occ;
    time t0;

    reset = 1'b0;
    clear0 = 1'b0; in_valid0 = 1'b1; in_data0 = 32'hAAAA_5555; out_ready0 = 1'b1;
    clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = 1'b0;         out_ready1 = 1'b1;
    clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;           out_ready2 = 1'b1;

    // Reset with an input beat held at the port.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid0), 128'(0));
    check("rst_out_data",  128'(out_data0),  128'(0));
    check("rst_occupancy", 128'(occ0),       128'(0));
    check("rst_in_ready",  128'(in_ready0),  128'(1));
    clear0 = 1'b1;
    #1;
    check("rst_in_ready_clear", 128'(in_ready0), 128'(0));
    clear0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // The first edge after reset release takes the beat. The beat is visible
    // on the output DEPTH = 4 cycles after acceptance.
    send0(32'hAAAA_5555, 1'b1);
    in_valid0 = 1'b0;
    lat = 0;
    c = 0;
    while (lat == 0 && c < 12) begin
      @(negedge clk);
      c++;
      if (out_valid0) lat = c;
    end
    check("latency_depth4", 128'(lat), 128'(4));
    @(posedge clk);
    #1;
    drain(0);

    // Streaming: 20 beats back to back, one per cycle.
    out_ready0 = 1'b1;
    t0 = $time;
    for (int k = 1; k <= 20; k++) begin
      send0(32'(k) * 32'h0001_0001, 1'b1);
      check("stream_occupancy", 128'(occ0), 128'((k < 4) ? k : 4));
    end
    check("stream_one_per_cycle", 128'(($time - t0) / 10), 128'(20));
    in_valid0 = 1'b0;
    drain(0);

    // Full bank under back-pressure, then release.
    out_ready0 = 1'b0;
    for (int i = 1; i <= 4; i++) send0(32'h1000_0000 + 32'(i), 1'b1);
    in_valid0 = 1'b1;
    in_data0  = 32'h1000_0005;
    @(negedge clk);
    check("full_in_ready", 128'(in_ready0), 128'(0));
    check("full_occupancy", 128'(occ0), 128'(4));
    @(posedge clk);
    #1;
    check("full_still_stalled", 128'(in_ready0), 128'(0));
    out_ready0 = 1'b1;
    #1;
    check("full_ready_same_cycle", 128'(in_ready0), 128'(1));
    send0(32'h1000_0005, 1'b1);
    check("full_occupancy_in_out", 128'(occ0), 128'(4));
    send0(32'h1000_0006, 1'b1);
    in_valid0 = 1'b0;
    drain(0);

    // Bubble collapse: A, idle, idle, B with the output stalled.
    out_ready0 = 1'b0;
    send0(32'h0000_00A0, 1'b1);
    in_valid0 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send0(32'h0000_00B0, 1'b1);
    in_valid0 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("bubble_occupancy", 128'(occ0), 128'(2));
    check("bubble_out_valid", 128'(out_valid0), 128'(1));
    check("bubble_in_ready", 128'(in_ready0), 128'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bubble_hold_occupancy", 128'(occ0), 128'(2));
    // B sits in stage 2, so it reaches the output right after A leaves.
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    check("bubble_b_next", 128'(out_valid0), 128'(1));
    check("bubble_occ_after_a", 128'(occ0), 128'(1));
    @(posedge clk);
    #1;
    check("bubble_empty", 128'(occ0), 128'(0));
    drain(0);

    // Clear mid-stream with three beats in the bank.
    out_ready0 = 1'b0;
    for (int i = 1; i <= 3; i++) send0(32'hDEAD_0000 + 32'(i), 1'b0);
    check("clear_pre_occupancy", 128'(occ0), 128'(3));
    in_valid0  = 1'b1;
    in_data0   = 32'hDEAD_0004;
    out_ready0 = 1'b1;
    clear0     = 1'b1;
    #1;
    check("clear_in_ready", 128'(in_ready0), 128'(0));
    check("clear_out_valid", 128'(out_valid0), 128'(0));
    @(posedge clk);
    #1;
    clear0    = 1'b0;
    in_valid0 = 1'b0;
    check("clear_occupancy", 128'(occ0), 128'(0));
    check("clear_out_valid_after", 128'(out_valid0), 128'(0));
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("clear_stays_empty", 128'(occ0), 128'(0));

    // DEPTH 1 bank: one-cycle latency, full at one beat.
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    @(negedge clk);
    check("d1_in_ready", 128'(in_ready1), 128'(1));
    if (in_ready1) q1.push_back(1'b1);
    out_ready1 = 1'b0;
    @(posedge clk);
    #1;
    check("d1_latency", 128'(out_valid1), 128'(1));
    check("d1_occupancy", 128'(occ1), 128'(1));
    in_data1 = 1'b0;
    #1;
    check("d1_full_stall", 128'(in_ready1), 128'(0));
    out_ready1 = 1'b1;
    #1;
    check("d1_ready_same_cycle", 128'(in_ready1), 128'(1));
    @(negedge clk);
    if (in_ready1) q1.push_back(1'b0);
    @(posedge clk);
    #1;
    in_data1 = 1'b1;
    @(negedge clk);
    if (in_ready1) q1.push_back(1'b1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    drain(1);

    // DEPTH 8 bank with four 24-bit channels: latency and channel packing.
    in_valid2 = 1'b1;
    in_data2  = {24'hABCDEF, 24'h333333, 24'h222222, 24'h111111};
    @(negedge clk);
    check("d8_in_ready", 128'(in_ready2), 128'(1));
    if (in_ready2) q2.push_back(in_data2);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 0;
    c = 0;
    while (lat == 0 && c < 20) begin
      @(negedge clk);
      c++;
      if (out_valid2) lat = c;
    end
    check("d8_latency", 128'(lat), 128'(8));
    check("d8_channel3", 128'(out_data2[95:72]), 128'(24'hABCDEF));
    @(posedge clk);
    #1;
    drain(2);

    // Ten beats into a stalled DEPTH 8 bank: only eight are taken.
    out_ready2 = 1'b0;
    n_acc = 0;
    max_occ = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid2 = 1'b1;
      in_data2  = {24'h300000 + 24'(i), 24'h200000 + 24'(i), 24'h100000 + 24'(i), 24'(i)};
      @(negedge clk);
      if (int'(occ2) > max_occ) max_occ = int'(occ2);
      if (in_ready2) begin
        q2.push_back(in_data2);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    check("d8_accepted", 128'(n_acc), 128'(8));
    check("d8_occupancy_full", 128'(occ2), 128'(8));
    check("d8_max_occupancy", 128'(max_occ), 128'(8));
    check("d8_full_in_ready", 128'(in_ready2), 128'(0));
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    drain(2);

    check("final_q0_empty", 128'(q0.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_pipe_stage_bank.md
# cordic_pipe_stage_bank

Parametrised, multi-channel elastic pipeline register bank for the CORDIC datapath. It carries CHANNELS lock-stepped words of WIDTH bits through DEPTH register stages under a valid/ready handshake. Bubbles collapse under back-pressure, and a synchronous flush empties the bank. It replaces the fixed-width, fixed-count flop wrappers between CORDIC iteration stages and adds stall, flush and occupancy behaviour.

## Interface
- WIDTH, 16, bits per channel word (>=1)
- CHANNELS, 2, number of words carried per beat (>=1)
- DEPTH, 4, number of register stages (>=1)
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; clock clk
- clear  input  1  synchronous flush, active-high
- in_valid  input  1  input beat present
- in_ready  output  1  bank accepts the input beat this cycle
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- out_valid  output  1  output beat present (stage DEPTH-1 valid)
- out_ready  input  1  downstream accepts the output beat
- out_data  output  CHANNELS*WIDTH  stage DEPTH-1 data, same packing as in_data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- Each stage i (0..DEPTH-1) holds a valid bit v[i] and a CHANNELS*WIDTH data register d[i]. All channels move together; there are no per-channel valids.
- Stage acceptance: rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready; rdy[i] = ~v[i] | rdy[i+1]. Ready is combinational back through the chain.
- in_ready = rdy[0] & ~clear; out_valid = v[DEPTH-1] & ~clear; out_data = d[DEPTH-1].
- On each edge with rdy[i] = 1: v[i] <= v[i-1] and d[i] <= d[i-1]. For stage 0 the sources are in_valid & in_ready and in_data.
- d[i] loads only when rdy[i] = 1 and the incoming valid is 1. Data of empty or stalled stages holds.
- A stage with rdy[i] = 0 holds both v[i] and d[i].
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready. Both can occur in the same cycle.
- clear = 1: all v[i] <= 0 on the edge. No input is accepted and no output transfer occurs in that cycle. d[i] holds. clear overrides every other input.
- occupancy = popcount(v) and is registered-consistent, i.e. it reflects the current v, not the next v.
- Reset (reset = 0, async): all v[i] = 0, all d[i] = 0. Outputs during reset: out_valid = 0, out_data = 0, occupancy = 0, in_ready = ~clear.
- Reset released mid-traffic: the first beat is accepted on the first rising edge after reset goes high.

## Timing
- Latency with no stall: a beat accepted at edge N appears as out_valid = 1 after edge N+DEPTH-1. It is visible for the cycle following that edge, so the accept-to-out_valid latency is DEPTH cycles.
- Throughput: 1 beat per cycle while out_ready = 1.
- Full: occupancy = DEPTH and out_ready = 0 gives in_ready = 0. If out_ready rises in the same cycle, in_ready = 1 in that cycle, with no lost cycle.
- Bubble collapse: an empty stage accepts even when downstream is stalled. Gaps between beats close under out_ready = 0.
- Empty: occupancy = 0, out_valid = 0, in_ready = 1 (unless clear).
- Simultaneous in/out transfer at full: occupancy stays DEPTH.
- Ordering is strictly FIFO. Beats are never dropped or duplicated except by clear or reset.

## Test plan
- Reset: hold reset = 0 with in_valid = 1, in_data = 0xAAAA_5555 -> out_valid = 0, out_data = 0, occupancy = 0. Release reset, drive the beat once -> out_valid = 1 exactly DEPTH = 4 cycles later with out_data = 0xAAAA_5555.
- Streaming: out_ready = 1, drive in_data = k*0x0001_0001 for k = 1..20 back-to-back -> same sequence on out_data, one beat per cycle, first beat 4 cycles after first accept, occupancy steady at 4.
- Full/back-pressure: out_ready = 0, drive 6 beats -> 4 accepted, in_ready = 0 from the 5th, occupancy = 4. Raise out_ready -> in_ready = 1 in the same cycle, beats 1..6 emerge in order.
- Bubble collapse: out_ready = 0, drive beats A, idle, idle, B -> A in stage 3, B settles in stage 2 within 2 cycles, occupancy = 2.
- Clear mid-stream: occupancy = 3, assert clear for 1 cycle with in_valid = 1 and out_ready = 1 -> in_ready = 0 and out_valid = 0 that cycle, occupancy = 0 next cycle, and no flushed beat ever appears.
- Parameter sweep: DEPTH = 1, CHANNELS = 1, WIDTH = 1 and DEPTH = 8, CHANNELS = 4, WIDTH = 24 -> latency = DEPTH, occupancy never exceeds DEPTH, per-channel packing preserved (channel 3 = in_data[95:72]).
